// File: rtl/trace_entry_spram_if.sv
// Port-A bundle of the trace-entry RAM: shared address, per-granule write enables,
// write data, final-stage clock enable and read data.
interface trace_entry_spram_if #(
  parameter int unsigned ADDR_WIDTH_A       = 6,
  parameter int unsigned WRITE_DATA_WIDTH_A = 48,
  parameter int unsigned READ_DATA_WIDTH_A  = 48,
  parameter int unsigned NWE                = 1
);
  logic                          ena;
  logic [NWE-1:0]                wea;
  logic [ADDR_WIDTH_A-1:0]       addra;
  logic [WRITE_DATA_WIDTH_A-1:0] dina;
  logic                          regcea;
  logic [READ_DATA_WIDTH_A-1:0]  douta;

  modport master (
    output ena, wea, addra, dina, regcea,
    input  douta
  );

  modport slave (
    input  ena, wea, addra, dina, regcea,
    output douta
  );
endinterface

// File: rtl/trace_entry_spram.sv
// Single-port RAM holding captured trace entries: shared address for reads and writes,
// granule write enables, selectable write-collision mode and a 1..8 stage read pipeline.
module trace_entry_spram #(
  parameter int unsigned                  ADDR_WIDTH_A       = 6,
  parameter int unsigned                  MEMORY_SIZE        = 3072,
  parameter int unsigned                  WRITE_DATA_WIDTH_A = 48,
  parameter int unsigned                  READ_DATA_WIDTH_A  = 48,
  parameter int unsigned                  BYTE_WRITE_WIDTH_A = 48,
  parameter int unsigned                  READ_LATENCY_A     = 1,
  parameter logic [READ_DATA_WIDTH_A-1:0] READ_RESET_VALUE_A = 'hFF,
  parameter string                        WRITE_MODE_A       = "no_change"
) (
  input logic                clk,
  input logic                rst_n,
  trace_entry_spram_if.slave io_bus
);
  localparam int unsigned Depth         = MEMORY_SIZE / WRITE_DATA_WIDTH_A;
  localparam int unsigned Nwe           = WRITE_DATA_WIDTH_A / BYTE_WRITE_WIDTH_A;
  localparam int unsigned Dw            = WRITE_DATA_WIDTH_A;
  localparam int unsigned Bw            = BYTE_WRITE_WIDTH_A;
  localparam bit          ModeNoChange  = (WRITE_MODE_A == "no_change");
  localparam bit          ModeReadFirst = (WRITE_MODE_A == "read_first");

  logic [Dw-1:0] r_mem [Depth] = '{default: '0};

  logic          w_in_range;
  logic          w_is_write;
  logic [Dw-1:0] w_old;
  logic [Dw-1:0] w_merged;
  logic          w_ld1;
  logic [Dw-1:0] w_st1;
  logic [Dw-1:0] r_douta;

  assign w_in_range = (32'(io_bus.addra) < Depth);
  assign w_is_write = |io_bus.wea;
  assign w_old      = w_in_range ? r_mem[io_bus.addra] : '0;

  always_comb begin
    w_merged = w_old;
    for (int g = 0; g < int'(Nwe); g++) begin
      if (io_bus.wea[g]) w_merged[g*Bw +: Bw] = io_bus.dina[g*Bw +: Bw];
    end
  end

  // In no_change mode a write leaves stage 1 (and its token) untouched.
  assign w_ld1 = io_bus.ena && (!w_is_write || !ModeNoChange);
  always_comb begin
    w_st1 = w_old;
    if (w_is_write && !ModeReadFirst) w_st1 = w_in_range ? w_merged : '0;
  end

  // Writes are not gated by reset: a write issued during reset still lands.
  always_ff @(posedge clk) begin
    if (io_bus.ena && w_is_write && w_in_range) r_mem[io_bus.addra] <= w_merged;
  end

  if (READ_LATENCY_A == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (!rst_n)     r_douta <= READ_RESET_VALUE_A;
      else if (w_ld1) r_douta <= w_st1;
    end
  end else begin : g_latn
    localparam int unsigned Ni = READ_LATENCY_A - 1;

    logic [Dw-1:0] r_pipe [Ni];
    logic [Ni-1:0] r_tok;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_tok <= '0;
      end else begin
        r_tok[0] <= w_ld1;
        for (int k = 1; k < int'(Ni); k++) r_tok[k] <= r_tok[k-1];
      end
    end

    // Intermediate data carry no reset; the tokens alone decide what is live.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        if (w_ld1) r_pipe[0] <= w_st1;
        for (int k = 1; k < int'(Ni); k++) begin
          if (r_tok[k-1]) r_pipe[k] <= r_pipe[k-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n)                              r_douta <= READ_RESET_VALUE_A;
      else if (r_tok[Ni-1] && io_bus.regcea) r_douta <= r_pipe[Ni-1];
    end
  end

  assign io_bus.douta = r_douta;
endmodule

// File: tb/tb_trace_entry_spram.sv
// Directed bench for trace_entry_spram: five instances cover the default configuration,
// both collision modes, granule writes with a short array, and a three-stage pipeline.
module tb_trace_entry_spram;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  trace_entry_spram_if #(.ADDR_WIDTH_A(6), .WRITE_DATA_WIDTH_A(48), .READ_DATA_WIDTH_A(48),
                         .NWE(1)) nc_if ();
  trace_entry_spram_if #(.ADDR_WIDTH_A(6), .WRITE_DATA_WIDTH_A(48), .READ_DATA_WIDTH_A(48),
                         .NWE(1)) rf_if ();
  trace_entry_spram_if #(.ADDR_WIDTH_A(6), .WRITE_DATA_WIDTH_A(48), .READ_DATA_WIDTH_A(48),
                         .NWE(1)) wf_if ();
  trace_entry_spram_if #(.ADDR_WIDTH_A(6), .WRITE_DATA_WIDTH_A(48), .READ_DATA_WIDTH_A(48),
                         .NWE(6)) bw_if ();
  trace_entry_spram_if #(.ADDR_WIDTH_A(6), .WRITE_DATA_WIDTH_A(48), .READ_DATA_WIDTH_A(48),
                         .NWE(1)) l3_if ();

  trace_entry_spram u_nc (.clk(clk), .rst_n(rst_n), .io_bus(nc_if));
  trace_entry_spram #(.WRITE_MODE_A("read_first")) u_rf (.clk(clk), .rst_n(rst_n),
                                                         .io_bus(rf_if));
  trace_entry_spram #(.WRITE_MODE_A("write_first")) u_wf (.clk(clk), .rst_n(rst_n),
                                                          .io_bus(wf_if));
  // 40-deep array so addresses 40..63 are out of range.
  trace_entry_spram #(.MEMORY_SIZE(1920), .BYTE_WRITE_WIDTH_A(8)) u_bw (.clk(clk),
                                                                         .rst_n(rst_n),
                                                                         .io_bus(bw_if));
  trace_entry_spram #(.READ_LATENCY_A(3)) u_l3 (.clk(clk), .rst_n(rst_n), .io_bus(l3_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    if (nc_if.douta !== 48'h0000_0000_00FF)
      $display("FAIL reset_nc got=%h exp=%h", nc_if.douta, 48'hFF);
    else n_pass++;
    n_total++;
    if (l3_if.douta !== 48'h0000_0000_00FF)
      $display("FAIL reset_l3 got=%h exp=%h", l3_if.douta, 48'hFF);
    else n_pass++;
    n_total++;
    if (bw_if.douta !== 48'h0000_0000_00FF)
      $display("FAIL reset_bw got=%h exp=%h", bw_if.douta, 48'hFF);
    else n_pass++;
    n_total++;
    rst_n = 1'b1;
    nc_if.ena = 1'b1; nc_if.wea = 1'b0; nc_if.addra = 6'd5;
    tick();
    nc_if.ena = 1'b0;
    if (nc_if.douta !== 48'h0)
      $display("FAIL reset_read5 got=%h exp=%h", nc_if.douta, 48'h0);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_write_read();
    nc_if.ena = 1'b1; nc_if.wea = 1'b1; nc_if.addra = 6'd3; nc_if.dina = 48'h1234_DEAD_BEEF;
    tick();
    nc_if.wea = 1'b0;
    tick();
    if (nc_if.douta !== 48'h1234_DEAD_BEEF)
      $display("FAIL wr_rd3 got=%h exp=%h", nc_if.douta, 48'h1234_DEAD_BEEF);
    else n_pass++;
    n_total++;
    nc_if.addra = 6'd4;
    tick();
    if (nc_if.douta !== 48'h0)
      $display("FAIL rd4_zero got=%h exp=%h", nc_if.douta, 48'h0);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_no_change();
    nc_if.addra = 6'd3;
    tick();
    nc_if.wea = 1'b1; nc_if.dina = 48'hAAAA;
    tick();
    if (nc_if.douta !== 48'h1234_DEAD_BEEF)
      $display("FAIL nochange_hold got=%h exp=%h", nc_if.douta, 48'h1234_DEAD_BEEF);
    else n_pass++;
    n_total++;
    nc_if.wea = 1'b0;
    tick();
    if (nc_if.douta !== 48'hAAAA)
      $display("FAIL nochange_read got=%h exp=%h", nc_if.douta, 48'hAAAA);
    else n_pass++;
    n_total++;
    nc_if.ena = 1'b0; nc_if.addra = 6'd4;
    tick();
    tick();
    if (nc_if.douta !== 48'hAAAA)
      $display("FAIL idle_hold got=%h exp=%h", nc_if.douta, 48'hAAAA);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_write_modes();
    rf_if.ena = 1'b1; rf_if.wea = 1'b1; rf_if.addra = 6'd7; rf_if.dina = 48'd1;
    wf_if.ena = 1'b1; wf_if.wea = 1'b1; wf_if.addra = 6'd7; wf_if.dina = 48'd1;
    tick();
    if (rf_if.douta !== 48'd0)
      $display("FAIL rf_first_old got=%h exp=%h", rf_if.douta, 48'd0);
    else n_pass++;
    n_total++;
    if (wf_if.douta !== 48'd1)
      $display("FAIL wf_first_new got=%h exp=%h", wf_if.douta, 48'd1);
    else n_pass++;
    n_total++;
    rf_if.dina = 48'd2;
    wf_if.dina = 48'd2;
    tick();
    if (rf_if.douta !== 48'd1)
      $display("FAIL rf_collide got=%h exp=%h", rf_if.douta, 48'd1);
    else n_pass++;
    n_total++;
    if (wf_if.douta !== 48'd2)
      $display("FAIL wf_collide got=%h exp=%h", wf_if.douta, 48'd2);
    else n_pass++;
    n_total++;
    rf_if.wea = 1'b0;
    tick();
    rf_if.ena = 1'b0;
    wf_if.ena = 1'b0; wf_if.wea = 1'b0;
    if (rf_if.douta !== 48'd2)
      $display("FAIL rf_readback got=%h exp=%h", rf_if.douta, 48'd2);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_byte_writes();
    bw_if.ena = 1'b1; bw_if.wea = 6'b000101; bw_if.addra = 6'd0;
    bw_if.dina = 48'hFFFF_FFFF_FFFF;
    tick();
    bw_if.wea = 6'b000000;
    tick();
    if (bw_if.douta !== 48'h0000_00FF_00FF)
      $display("FAIL granule_a got=%h exp=%h", bw_if.douta, 48'h0000_00FF_00FF);
    else n_pass++;
    n_total++;
    bw_if.wea = 6'b100000; bw_if.dina = 48'h1234_5678_9ABC;
    tick();
    bw_if.wea = 6'b000000;
    tick();
    if (bw_if.douta !== 48'h1200_00FF_00FF)
      $display("FAIL granule_b got=%h exp=%h", bw_if.douta, 48'h1200_00FF_00FF);
    else n_pass++;
    n_total++;
    bw_if.wea = 6'b000011; bw_if.addra = 6'd39; bw_if.dina = 48'h5555_5555_ABCD;
    tick();
    bw_if.wea = 6'b000000;
    tick();
    if (bw_if.douta !== 48'h0000_0000_ABCD)
      $display("FAIL last_addr got=%h exp=%h", bw_if.douta, 48'h0000_0000_ABCD);
    else n_pass++;
    n_total++;
    bw_if.wea = 6'b111111; bw_if.addra = 6'd50; bw_if.dina = 48'hFFFF_FFFF_FFFF;
    tick();
    bw_if.wea = 6'b000000;
    tick();
    if (bw_if.douta !== 48'h0)
      $display("FAIL oor_read got=%h exp=%h", bw_if.douta, 48'h0);
    else n_pass++;
    n_total++;
    bw_if.addra = 6'd10;
    tick();
    bw_if.ena = 1'b0;
    if (bw_if.douta !== 48'h0)
      $display("FAIL oor_alias got=%h exp=%h", bw_if.douta, 48'h0);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_latency3();
    l3_if.regcea = 1'b1;
    l3_if.ena = 1'b1; l3_if.wea = 1'b1;
    for (int a = 0; a < 3; a++) begin
      l3_if.addra = 6'(a);
      l3_if.dina  = 48'h100 + 48'(a);
      tick();
    end
    l3_if.wea = 1'b0;
    l3_if.addra = 6'd0;
    tick();
    if (l3_if.douta !== 48'hFF)
      $display("FAIL l3_edge1 got=%h exp=%h", l3_if.douta, 48'hFF);
    else n_pass++;
    n_total++;
    l3_if.addra = 6'd1;
    tick();
    if (l3_if.douta !== 48'hFF)
      $display("FAIL l3_edge2 got=%h exp=%h", l3_if.douta, 48'hFF);
    else n_pass++;
    n_total++;
    l3_if.addra = 6'd2;
    tick();
    if (l3_if.douta !== 48'h100)
      $display("FAIL l3_data0 got=%h exp=%h", l3_if.douta, 48'h100);
    else n_pass++;
    n_total++;
    l3_if.ena = 1'b0;
    tick();
    if (l3_if.douta !== 48'h101)
      $display("FAIL l3_data1 got=%h exp=%h", l3_if.douta, 48'h101);
    else n_pass++;
    n_total++;
    tick();
    if (l3_if.douta !== 48'h102)
      $display("FAIL l3_data2 got=%h exp=%h", l3_if.douta, 48'h102);
    else n_pass++;
    n_total++;
    tick();
    if (l3_if.douta !== 48'h102)
      $display("FAIL l3_hold got=%h exp=%h", l3_if.douta, 48'h102);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_regcea_stall();
    l3_if.regcea = 1'b0;
    l3_if.ena = 1'b1; l3_if.addra = 6'd0;
    tick();
    l3_if.ena = 1'b0;
    tick();
    tick();
    if (l3_if.douta !== 48'h102)
      $display("FAIL stall_freeze got=%h exp=%h", l3_if.douta, 48'h102);
    else n_pass++;
    n_total++;
    // The stalled word's token has already moved on, so re-enabling does not release it.
    l3_if.regcea = 1'b1;
    tick();
    if (l3_if.douta !== 48'h102)
      $display("FAIL stall_lost got=%h exp=%h", l3_if.douta, 48'h102);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reset_mid_stream();
    l3_if.ena = 1'b1; l3_if.addra = 6'd0;
    tick();
    l3_if.addra = 6'd1;
    tick();
    rst_n = 1'b0; l3_if.addra = 6'd2;
    tick();
    if (l3_if.douta !== 48'hFF)
      $display("FAIL midrst_value got=%h exp=%h", l3_if.douta, 48'hFF);
    else n_pass++;
    n_total++;
    rst_n = 1'b1; l3_if.ena = 1'b0;
    tick();
    tick();
    tick();
    if (l3_if.douta !== 48'hFF)
      $display("FAIL midrst_stale got=%h exp=%h", l3_if.douta, 48'hFF);
    else n_pass++;
    n_total++;
    l3_if.ena = 1'b1; l3_if.addra = 6'd2;
    tick();
    l3_if.ena = 1'b0;
    tick();
    if (l3_if.douta !== 48'hFF)
      $display("FAIL postrst_early got=%h exp=%h", l3_if.douta, 48'hFF);
    else n_pass++;
    n_total++;
    tick();
    if (l3_if.douta !== 48'h102)
      $display("FAIL postrst_read got=%h exp=%h", l3_if.douta, 48'h102);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_write_during_reset();
    rst_n = 1'b0;
    nc_if.ena = 1'b1; nc_if.wea = 1'b1; nc_if.addra = 6'd9; nc_if.dina = 48'h99;
    tick();
    if (nc_if.douta !== 48'hFF)
      $display("FAIL rstwr_douta got=%h exp=%h", nc_if.douta, 48'hFF);
    else n_pass++;
    n_total++;
    rst_n = 1'b1; nc_if.wea = 1'b0;
    tick();
    nc_if.ena = 1'b0;
    if (nc_if.douta !== 48'h99)
      $display("FAIL rstwr_read got=%h exp=%h", nc_if.douta, 48'h99);
    else n_pass++;
    n_total++;
  endtask

  initial begin
    nc_if.ena = 1'b0; nc_if.wea = '0; nc_if.addra = '0; nc_if.dina = '0; nc_if.regcea = 1'b1;
    rf_if.ena = 1'b0; rf_if.wea = '0; rf_if.addra = '0; rf_if.dina = '0; rf_if.regcea = 1'b1;
    wf_if.ena = 1'b0; wf_if.wea = '0; wf_if.addra = '0; wf_if.dina = '0; wf_if.regcea = 1'b1;
    bw_if.ena = 1'b0; bw_if.wea = '0; bw_if.addra = '0; bw_if.dina = '0; bw_if.regcea = 1'b1;
    l3_if.ena = 1'b0; l3_if.wea = '0; l3_if.addra = '0; l3_if.dina = '0; l3_if.regcea = 1'b1;
    test_reset();
    test_write_read();
    test_no_change();
    test_write_modes();
    test_byte_writes();
    test_latency3();
    test_regcea_stall();
    test_reset_mid_stream();
    test_write_during_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
